mem_max_scanner: RTL and testbench

Bus-master block that drives the data-memory port (Address, WriteData, MemRead, MemWrite, ReadData) from the initiator side. On a start pulse it reads `count` consecutive bytes beginning at `base_addr`, finds the maximum and its offset, and writes the maximum back to `dest_addr`. It then pulses `done`. It sits beside the datapath as a memory-side accelerator and connects by port name to the data memory.

---
 rtl/mem_scan_pkg.sv | 24 ++
 rtl/mem_max_scanner_max_compare.sv | 22 ++
 rtl/mem_max_scanner.sv | 163 ++++++++++++++++
 tb/tb_mem_max_scanner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_scan_pkg.sv
// Shared types and defaults for the memory max-scanner accelerator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_scan_pkg;

  // Scanner control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Default memory address and data widths
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;

  // Address of element `off` in a window starting at `base`, wrapping modulo 2^AW
  function automatic logic [DEF_AW-1:0] wrap_addr(input logic [DEF_AW-1:0] base,
                                                  input logic [DEF_AW-1:0] off);
    return base + off;
  endfunction

endpackage

// File: rtl/mem_max_scanner_max_compare.sv
// Strict greater-than comparator, unsigned or two's-complement by parameter.
// Latency: combinational.
// Backpressure: none.
module max_compare #(
  parameter int DW     = 8,
  parameter int SIGNED = 0
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic          gt_o
);

  // Select the compare flavour once at elaboration
  generate
    if (SIGNED != 0) begin : g_signed
      assign gt_o = $signed(a_i) > $signed(b_i);
    end else begin : g_unsigned
      assign gt_o = a_i > b_i;
    end
  endgenerate

endmodule

// File: rtl/mem_max_scanner.sv
// Scans count bytes from base_addr, finds the first maximum and writes it to dest_addr.
// Latency: count+2 cycles from accepted start to done (1 cycle when count==0).
// Backpressure: none; start is only honoured in IDLE, later starts are dropped.
module mem_max_scanner
  import mem_scan_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] count,
  input  logic [AW-1:0] dest_addr,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] max_val,
  output logic [AW-1:0] max_idx,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] WriteData,
  output logic          MemRead,
  output logic          MemWrite,
  input  logic [DW-1:0] ReadData
);

  state_e        state_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] cnt_q;
  logic [AW-1:0] dest_q;
  logic [AW-1:0] i_q;
  logic [DW-1:0] max_val_q;
  logic [AW-1:0] max_idx_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          rd_q;
  logic          wr_q;
  logic          busy_q;
  logic          done_q;

  logic          gt;
  logic          take;
  logic [DW-1:0] max_val_d;
  logic [AW-1:0] max_idx_d;
  logic          last_rd;

  max_compare #(
    .DW     (DW),
    .SIGNED (SIGNED)
  ) u_cmp (
    .a_i  (ReadData),
    .b_i  (max_val_q),
    .gt_o (gt)
  );

  // Running maximum including the byte being read this cycle; ties keep the older index
  always_comb begin
    take      = (i_q == '0) || gt;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    if (take) begin
      max_val_d = ReadData;
      max_idx_d = i_q;
    end
    last_rd   = (i_q == (cnt_q - AW'(1)));
  end

  // Control FSM with registered bus strobes, address, write data and status
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      dest_q    <= '0;
      i_q       <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            base_q    <= base_addr;
            cnt_q     <= count;
            dest_q    <= dest_addr;
            i_q       <= '0;
            max_val_q <= '0;
            max_idx_q <= '0;
            busy_q    <= 1'b1;
            if (count != '0) begin
              // First read is presented in the very next cycle
              state_q <= READ;
              addr_q  <= base_addr;
              rd_q    <= 1'b1;
            end else begin
              // Empty window: no bus traffic, straight to completion
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end

        READ: begin
          max_val_q <= max_val_d;
          max_idx_q <= max_idx_d;
          if (last_rd) begin
            // Write-back carries the maximum including the final byte
            state_q <= WRITE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b1;
            addr_q  <= dest_q;
            wdata_q <= max_val_d;
          end else begin
            i_q    <= i_q + AW'(1);
            addr_q <= base_q + i_q + AW'(1);
          end
        end

        WRITE: begin
          state_q <= DONE;
          wr_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          done_q  <= 1'b1;
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          i_q     <= '0;
        end

        default: begin
          state_q <= IDLE;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign max_val   = max_val_q;
  assign max_idx   = max_idx_q;
  assign Address   = addr_q;
  assign WriteData = wdata_q;
  assign MemRead   = rd_q;
  assign MemWrite  = wr_q;

endmodule

// File: tb/tb_mem_max_scanner.sv
// Bench: unsigned and signed scanners side by side, each with its own 256x8 memory.
// A schedule-level model predicts every cycle's outputs; literal checks pin the model.
module tb_mem_max_scanner;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [7:0] mv;
    logic [7:0] mi;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       rd;
    logic       wr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base, count, dest;

  logic       b0, d0, mr0, mw0, b1, d1, mr1, mw1;
  logic [7:0] mv0, mi0, a0, wd0, rd0, mv1, mi1, a1, wd1, rd1;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  logic [7:0] h0v, h0i, h1v, h1i;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  mem_max_scanner #(.AW(8), .DW(8), .SIGNED(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .count(count), .dest_addr(dest),
    .busy(b0), .done(d0), .max_val(mv0), .max_idx(mi0), .Address(a0), .WriteData(wd0),
    .MemRead(mr0), .MemWrite(mw0), .ReadData(rd0));

  mem_max_scanner #(.AW(8), .DW(8), .SIGNED(1)) u1 (
    .clk(clk), .rst(rst), .start(start), .base_addr(base), .count(count), .dest_addr(dest),
    .busy(b1), .done(d1), .max_val(mv1), .max_idx(mi1), .Address(a1), .WriteData(wd1),
    .MemRead(mr1), .MemWrite(mw1), .ReadData(rd1));

  // Zero-wait memories
  assign rd0 = mem0[a0];
  assign rd1 = mem1[a1];
  always @(posedge clk) begin
    if (mw0) mem0[a0] = wd0;
    if (mw1) mem1[a1] = wd1;
  end

  function automatic int val(input logic [7:0] v, input bit s);
    return s ? int'($signed(v)) : int'(v);
  endfunction

  function automatic exp_t idle_e(input logic [7:0] v, input logic [7:0] i);
    exp_t e;
    e = '0;
    e.mv = v;
    e.mi = i;
    return e;
  endfunction

  // Expected cycle-by-cycle trace of one scan: reads, write-back, done
  task automatic build(input bit sgn, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_t e;
    logic [7:0] mv, mi, ad, v;
    mv = 8'h00;
    mi = 8'h00;
    for (int k = 0; k < int'(c); k++) begin
      ad = b + k[7:0];
      e = '0;
      e.busy = 1'b1; e.mv = mv; e.mi = mi; e.addr = ad; e.rd = 1'b1;
      if (sgn) q1.push_back(e); else q0.push_back(e);
      v = sgn ? mem1[ad] : mem0[ad];
      if (k == 0 || val(v, sgn) > val(mv, sgn)) begin
        mv = v;
        mi = k[7:0];
      end
    end
    if (c != 8'd0) begin
      e = '0;
      e.busy = 1'b1; e.mv = mv; e.mi = mi; e.addr = d; e.wd = mv; e.wr = 1'b1;
      if (sgn) q1.push_back(e); else q0.push_back(e);
    end
    e = '0;
    e.busy = 1'b1; e.done = 1'b1; e.mv = mv; e.mi = mi;
    if (sgn) begin q1.push_back(e); h1v = mv; h1i = mi; end
    else     begin q0.push_back(e); h0v = mv; h0i = mi; end
  endtask

  // Reference: advance the expected outputs at each rising edge
  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      h0v = 0; h0i = 0; h1v = 0; h1i = 0;
      e0 = idle_e(8'h00, 8'h00);
      e1 = idle_e(8'h00, 8'h00);
    end else begin
      if (start && q0.size() == 0 && !e0.busy) build(1'b0, base, count, dest);
      if (start && q1.size() == 0 && !e1.busy) build(1'b1, base, count, dest);
      e0 = (q0.size() != 0) ? q0.pop_front() : idle_e(h0v, h0i);
      e1 = (q1.size() != 0) ? q1.pop_front() : idle_e(h1v, h1i);
    end
    armed = 1'b1;
  end

  task automatic chk(input string nm, input exp_t a, input exp_t e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s t=%0t {busy,done,mv,mi,addr,wd,rd,wr} act=%h exp=%h", nm, $time, a, e);
    end
  endtask

  // Every-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("cycle_unsigned", {b0, d0, mv0, mi0, a0, wd0, mr0, mw0}, e0);
      chk("cycle_signed",   {b1, d1, mv1, mi1, a1, wd1, mr1, mw1}, e1);
    end
  end

  task automatic lit(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  int wr_cnt;

  // One scan request; returns cycles until done (or until the cycle after a planted reset)
  task automatic run(input logic [7:0] b, input logic [7:0] c, input logic [7:0] d,
                     input int xs, input int rc, output int cyc);
    @(negedge clk);
    base = b; count = c; dest = d; start = 1'b1;
    cyc = 0;
    wr_cnt = 0;
    while (cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = (cyc == xs);
      rst   = (cyc == rc);
      if (mw0) wr_cnt++;
      if (rc > 0 && cyc == rc + 1) return;
      if (d0) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL timeout waiting for done base=%0d count=%0d", b, c);
  endtask

  task automatic fill_random();
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      mem0[i] = v;
      mem1[i] = v;
    end
  endtask

  task automatic poke(input int a, input logic [7:0] v);
    mem0[a] = v;
    mem1[a] = v;
  endtask

  logic [7:0] scen1 [15];
  int cyc;
  int keep;

  initial begin
    rst = 1'b1; start = 1'b0; base = 0; count = 0; dest = 0;
    fill_random();
    repeat (3) @(negedge clk);
    lit("reset_busy", int'(b0), 0);
    lit("reset_strobes", int'({mr0, mw0, mr1, mw1}), 0);
    lit("reset_addr_wd", int'({a0, wd0}), 0);
    lit("reset_max", int'({mv0, mi0, mv1, mi1}), 0);
    rst = 1'b0;

    // Scenario 1/2: unsigned and signed scans over the same window
    scen1 = '{8'h15, 8'h14, 8'h1D, 8'h11, 8'h14, 8'h35, 8'hF5, 8'h1F,
              8'h34, 8'h55, 8'h75, 8'h7F, 8'h17, 8'hE0, 8'hFF};
    for (int k = 0; k < 15; k++) poke(106 + k, scen1[k]);
    run(8'd106, 8'd15, 8'd200, 0, 0, cyc);
    lit("s1_latency", cyc, 17);
    lit("s1_u_max", int'(mv0), 8'hFF);
    lit("s1_u_idx", int'(mi0), 14);
    lit("s1_s_max", int'(mv1), 8'h7F);
    lit("s1_s_idx", int'(mi1), 11);
    lit("s1_writes", wr_cnt, 1);
    @(negedge clk);
    lit("s1_u_mem", int'(mem0[200]), 8'hFF);
    lit("s1_s_mem", int'(mem1[200]), 8'h7F);

    // Ties and address wrap
    poke(254, 8'h40); poke(255, 8'h90); poke(0, 8'h90); poke(1, 8'h10);
    run(8'd254, 8'd4, 8'd10, 0, 0, cyc);
    lit("wrap_latency", cyc, 6);
    lit("wrap_u_max", int'(mv0), 8'h90);
    lit("wrap_u_idx", int'(mi0), 1);
    lit("wrap_s_max", int'(mv1), 8'h40);
    lit("wrap_s_idx", int'(mi1), 0);
    @(negedge clk);
    lit("wrap_u_mem", int'(mem0[10]), 8'h90);
    lit("wrap_s_mem", int'(mem1[10]), 8'h40);

    // Empty window
    run(8'd5, 8'd0, 8'd77, 0, 0, cyc);
    lit("cnt0_latency", cyc, 1);
    lit("cnt0_max", int'({mv0, mi0}), 0);
    lit("cnt0_writes", wr_cnt, 0);

    // Start while busy is dropped
    run(8'd106, 8'd15, 8'd200, 3, 0, cyc);
    lit("busy_start_latency", cyc, 17);
    lit("busy_start_max", int'(mv0), 8'hFF);
    @(negedge clk);
    lit("busy_start_idle", int'(b0), 0);

    // Reset in cycle 5 of a scan
    keep = int'(mem0[201]);
    run(8'd106, 8'd15, 8'd201, 0, 5, cyc);
    lit("rst_outputs", int'({b0, d0, mv0, mi0, a0, wd0, mr0, mw0}), 0);
    lit("rst_no_write", wr_cnt, 0);
    lit("rst_dest_kept", int'(mem0[201]), keep);
    run(8'd106, 8'd15, 8'd202, 0, 0, cyc);
    lit("post_rst_latency", cyc, 17);
    lit("post_rst_max", int'(mv0), 8'hFF);

    // Randomised scans; the per-cycle model does the checking
    for (int t = 0; t < 10; t++) begin
      logic [7:0] rb, rcnt, rd;
      fill_random();
      rb   = 8'($urandom);
      rcnt = (t == 0) ? 8'd255 : 8'($urandom_range(0, 40));
      rd   = 8'($urandom);
      run(rb, rcnt, rd, (t % 3 == 1) ? 2 : 0, 0, cyc);
      lit("rand_latency", cyc, (rcnt == 0) ? 1 : int'(rcnt) + 2);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
